// File: rtl/deser32_1.sv
// Serial-to-parallel collector: assembles WIDTH serial bits into a registered word with valid/ready output.
// Build option: define DESER32_MSB_FIRST_EN to place the first accepted bit at dout[WIDTH-1].
module deser32_1 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready
);

   localparam int IW = $clog2(WIDTH);
   localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

   logic [WIDTH-1:0] shadow;
   logic [WIDTH-1:0] word_next;
   logic [IW-1:0]    idx;
   logic [IW-1:0]    pos;
   logic             at_last;
   logic             accept;
   logic             complete;

   assign at_last   = (idx == LAST_IDX);
   // Only the final bit of a word can stall; the output register frees up on consume.
   assign din_ready = !(at_last && dout_valid && !dout_ready);
   assign accept    = din_valid && din_ready && !clear;
   assign complete  = accept && at_last;

`ifdef DESER32_MSB_FIRST_EN
   assign pos = LAST_IDX - idx;
`else
   assign pos = idx;
`endif

   always_comb begin
      word_next      = shadow;
      word_next[pos] = din;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow     <= '0;
         idx        <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
      end else begin
         if (clear) begin
            idx <= '0;
         end else if (accept) begin
            shadow <= word_next;
            idx    <= idx + IW'(1);
         end

         // A completing word takes priority over a consume in the same cycle.
         if (complete) begin
            dout       <= word_next;
            dout_valid <= 1'b1;
         end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/deser32_1.md
# deser32_1

Serial-to-parallel collector: the write/assembly end of the 32-to-1 bit-select path. It accepts one data bit per valid cycle and places successive bits at ascending word positions 0..WIDTH-1. Each completed word is presented on a registered parallel output under a valid/ready handshake. One partially assembled word can be collected while a completed word waits on the output, which gives double buffering.

## Interface
- WIDTH, 32, word width in bits; a power of two, at least 2. Index width IW = $clog2(WIDTH).
- clk  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high.
- clear  input  1  synchronous; discards the partial word.
- din  input  1  serial data bit.
- din_valid  input  1  din is valid this cycle.
- din_ready  output  1  block accepts din this cycle.
- dout  output  WIDTH  completed word (registered).
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer takes dout this cycle.

## Operation
- State:
  - shadow[WIDTH-1:0]: assembly register.
  - idx[IW-1:0]: next bit position.
  - dout / dout_valid: output register.
- Bit accept:
  - A bit is accepted when din_valid && din_ready.
  - On accept, shadow[pos] <= din and idx <= idx+1, wrapping from WIDTH-1 to 0.
  - pos = idx (LSB-first); see Configuration for MSB-first.
- Word completion:
  - Occurs when a bit is accepted at idx == WIDTH-1.
  - dout <= {din placed at pos, other bits from shadow}, dout_valid <= 1, idx <= 0.
- Output consume:
  - On dout_valid && dout_ready with no simultaneous completion, dout_valid <= 0.
  - dout keeps its last value.
- din_ready = !(idx == WIDTH-1 && dout_valid && !dout_ready).
  - din_ready stalls only the final bit of a word while the output is still occupied.
  - din_ready is combinational from dout_ready, idx and dout_valid; there is no din_valid → din_ready path.
- Simultaneous completion and consume: the new word loads and dout_valid stays 1.
- clear:
  - Sets idx <= 0. shadow contents are don't-care.
  - A bit offered in the same cycle is discarded, and completion is suppressed.
  - clear has no effect on dout or dout_valid.
- Bits of shadow not yet written in the current word are don't-care. They never reach dout, because a completed word has had every position written since the last idx=0.

## Timing
- Reset values:
  - din_ready = 1 (idx=0).
  - dout = 0, dout_valid = 0, idx = 0, shadow = 0.
- Reset mid-word or mid-handshake: all state returns to the reset values immediately (asynchronous). The partial word and any pending dout are lost.
- Latency: dout_valid rises on the clock edge that accepts bit WIDTH-1. The word is visible the cycle after that bit is presented.
- Throughput: one bit per cycle sustained when dout_ready=1. A WIDTH-bit word takes WIDTH cycles.
- Backpressure: with dout held unconsumed, WIDTH-1 bits of the next word are still accepted; the next bit stalls until dout_ready.

## Configuration
- DESER32_MSB_FIRST_EN defined:
  - pos = WIDTH-1-idx, so the first accepted bit lands in dout[WIDTH-1].
- DESER32_MSB_FIRST_EN not defined:
  - pos = idx, so the first accepted bit lands in dout[0] (LSB-first).
- Handshake, latency and all other behaviour are identical in both builds.

## Test plan
- Basic word:
  - Stimulus: reset, then feed 32'hC5540F26 LSB-first, one bit per cycle with din_valid=1 and dout_ready=0.
  - Required response: after bit 31, dout=32'hC5540F26 and dout_valid=1.
- Backpressure:
  - Stimulus: hold dout_ready=0 and continue with 32'h5D09A700.
  - Required response: bits 0..30 accepted; din_ready=0 at bit 31.
  - Then pulse dout_ready=1: in that cycle bit 31 is accepted and dout=32'h5D09A700 with dout_valid still 1.
- Clear:
  - Stimulus: feed 10 bits of all ones, pulse clear, then feed 32'h00000001.
  - Required response: dout=32'h00000001; no stale ones appear in dout.
- Async reset:
  - Stimulus: assert reset mid-clock after 20 bits with a pending dout.
  - Required response: dout_valid=0, dout=0 and din_ready=1 immediately.
  - A following 32'hFFFF0000 word assembles correctly.
- Gapped input:
  - Stimulus: deassert din_valid on random cycles (for example every third cycle) while sending 32'hA5A5A5A5.
  - Required response: dout=32'hA5A5A5A5.
- MSB-first build (DESER32_MSB_FIRST_EN defined):
  - Stimulus: feed 32'hC5540F26 MSB-first.
  - Required response: dout=32'hC5540F26.
